mc_maindec: RTL and testbench
=============================

MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter: ENABLE_BNE, default 1, when 1 opcode 000101 (bne) is decoded, otherwise it is illegal.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset is asynchronous and active-low.
REQ-004 Port: op  input  6  opcode of the instruction register; sampled only in DECODE.
REQ-005 Port: funct  input  6  funct field, used for R-type ALU control.
REQ-006 Ports: iord, irwrite, memwrite  output  1 each  unified instruction/data memory controls (0 = pc address, 1 = data address).
REQ-007 Ports: pcwrite, branch, branch_ne, regwrite, regdst, memtoreg, alusrca  output  1 each  datapath controls.
REQ-008 Ports: alusrcb, pcsrc, aluop  output  2 each; alucontrol  output  3; illegal  output  1; state  output  4 (debug).

Function
REQ-009 Moore FSM; states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-010 Transitions: FETCH->DECODE; DECODE by op: lw/sw (100011/101011)->MEMADR, R-type (000000)->EXECUTE, beq (000100)/bne->BRANCH, addi (001000)->ADDIEX, j (000010)->JUMP, anything else->FETCH.
REQ-011 MEMADR->MEMRD for lw, ->MEMWR for sw; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-012 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
REQ-013 Outputs are decoded from state only; any control not listed for a state is 0.
REQ-014 FETCH: irwrite=1, pcwrite=1, iord=0, alusrcb=01, aluop=00, pcsrc=00.
REQ-015 DECODE: alusrcb=11, aluop=00. MEMADR: alusrca=1, alusrcb=10.
REQ-016 MEMRD: iord=1. MEMWR: iord=1, memwrite=1. MEMWB: memtoreg=1, regwrite=1.
REQ-017 EXECUTE: alusrca=1, aluop=10. ALUWB: regdst=1, regwrite=1. ADDIEX: alusrca=1, alusrcb=10. ADDIWB: regwrite=1.
REQ-018 BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1 for beq, branch_ne=1 for bne (opcode registered in DECODE).
REQ-019 JUMP: pcsrc=10, pcwrite=1.
REQ-020 The memory read is registered: instruction capture completes at the end of FETCH and data capture at the end of MEMRD; the FSM never consumes read data in the same cycle as its address.
REQ-021 illegal pulses for exactly one cycle (in DECODE) on an unrecognised op; no write strobe is asserted for that instruction.
REQ-022 alucontrol: aluop 00->010 (add), 01->110 (sub), 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; aluop 11->010.
REQ-023 memwrite and irwrite are never asserted in the same cycle; memwrite is asserted only while iord=1.

Reset
REQ-024 resetn low forces state=FETCH immediately, independent of clk.
REQ-025 While resetn is low, pcwrite, irwrite, memwrite, regwrite, branch, branch_ne and illegal are 0; the other outputs hold their FETCH values.
REQ-026 Reset asserted mid-instruction (including MEMWR) aborts it with no further strobes; the first FETCH cycle follows the first rising edge after deassertion.

Structure
REQ-027 The shared package holds the state enum, the opcode and funct constants, and the alucontrol/aluop encodings.
REQ-028 ALU decode is the combinational sub-module alu_decoder (aluop, funct -> alucontrol); the FSM and the output decode stay in mc_maindec.

Verification
REQ-029 Reset release, op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; iord=1 in MEMRD; regwrite=1, memtoreg=1 only in cycle 5.
REQ-030 op=101011 -> 4 cycles; memwrite=1 with iord=1 only in MEMWR; regwrite never 1.
REQ-031 op=000000, funct=101010 -> alucontrol=111 in EXECUTE; ALUWB regdst=1, regwrite=1; 4 cycles total.
REQ-032 op=000101 with ENABLE_BNE=1 -> BRANCH with branch_ne=1, branch=0, pcsrc=01; with ENABLE_BNE=0 -> illegal=1 for one cycle, back in FETCH after 2 cycles.
REQ-033 op=000010 -> JUMP pcwrite=1, pcsrc=10, 3 cycles; op=001000 -> ADDIEX alusrcb=10, then ADDIWB regwrite=1, regdst=0.
REQ-034 resetn pulsed low asynchronously during MEMWR -> memwrite drops to 0 without a clock edge; state=FETCH; no write completes.

Source files
------------

// File: rtl/mc_maindec_pkg.sv
// Shared types and encodings for the multicycle main decoder.
package mc_maindec_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned AC_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    localparam logic [AC_W-1:0] AC_AND = 3'b000;
    localparam logic [AC_W-1:0] AC_OR  = 3'b001;
    localparam logic [AC_W-1:0] AC_ADD = 3'b010;
    localparam logic [AC_W-1:0] AC_SUB = 3'b110;
    localparam logic [AC_W-1:0] AC_SLT = 3'b111;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_e     aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_maindec_if.sv
// Instruction fields in, datapath controls out, between datapath and decoder.
interface mc_maindec_if;
    import mc_maindec_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               iord;
    logic               irwrite;
    logic               memwrite;
    logic               pcwrite;
    logic               branch;
    logic               branch_ne;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [1:0]         aluop;
    logic [AC_W-1:0]    alucontrol;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        output op, funct,
        input  iord, irwrite, memwrite, pcwrite, branch, branch_ne, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, alucontrol,
               illegal, state
    );

    modport slave (
        input  op, funct,
        output iord, irwrite, memwrite, pcwrite, branch, branch_ne, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, alucontrol,
               illegal, state
    );

endinterface

// File: rtl/mc_maindec_alu_decoder.sv
// Combinational ALU control: aluop plus R-type funct select the ALU operation.
module alu_decoder
    import mc_maindec_pkg::*;
(
    input  aluop_e             aluop_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [AC_W-1:0]    alucontrol_o
);

    always_comb begin
        alucontrol_o = AC_ADD;
        case (aluop_i)
            ALUOP_SUB:   alucontrol_o = AC_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    F_ADD:   alucontrol_o = AC_ADD;
                    F_SUB:   alucontrol_o = AC_SUB;
                    F_AND:   alucontrol_o = AC_AND;
                    F_OR:    alucontrol_o = AC_OR;
                    F_SLT:   alucontrol_o = AC_SLT;
                    default: alucontrol_o = AC_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: Moore FSM sequencing a unified-memory datapath.
module mc_maindec
    import mc_maindec_pkg::*;
#(
    parameter bit ENABLE_BNE = 1'b1
) (
    input logic         clk,
    input logic         resetn,
    mc_maindec_if.slave bus
);

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            run_q;
    logic            op_known_c;
    logic            illegal_c;
    ctrl_t           ctrl_c;

    // run_q holds the FSM in an idle FETCH until the first edge after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        op_known_c = (bus.op == OP_LW)   || (bus.op == OP_SW)  ||
                     (bus.op == OP_RTYPE) || (bus.op == OP_BEQ) ||
                     (bus.op == OP_ADDI) || (bus.op == OP_J)   ||
                     (ENABLE_BNE && (bus.op == OP_BNE));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        if (run_q) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    op_d = bus.op;
                    case (bus.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_BNE:       state_d = ENABLE_BNE ? S_BRANCH : S_FETCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   state_d = S_MEMWB;
                S_EXECUTE: state_d = S_ALUWB;
                S_ADDIEX:  state_d = S_ADDIWB;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    // Controls are a pure function of state; branch flavour comes from the captured opcode
    always_comb begin
        ctrl_c       = '0;
        ctrl_c.aluop = ALUOP_ADD;
        illegal_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.irwrite = 1'b1;
                ctrl_c.pcwrite = 1'b1;
                ctrl_c.alusrcb = 2'b01;
            end
            S_DECODE: begin
                ctrl_c.alusrcb = 2'b11;
                illegal_c      = !op_known_c;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = 2'b10;
            end
            S_MEMRD: ctrl_c.iord = 1'b1;
            S_MEMWR: begin
                ctrl_c.iord     = 1'b1;
                ctrl_c.memwrite = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.memtoreg = 1'b1;
                ctrl_c.regwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_c.regdst   = 1'b1;
                ctrl_c.regwrite = 1'b1;
            end
            S_ADDIWB: ctrl_c.regwrite = 1'b1;
            S_BRANCH: begin
                ctrl_c.alusrca   = 1'b1;
                ctrl_c.aluop     = ALUOP_SUB;
                ctrl_c.pcsrc     = 2'b01;
                ctrl_c.branch    = (op_q == OP_BEQ);
                ctrl_c.branch_ne = (op_q == OP_BNE);
            end
            S_JUMP: begin
                ctrl_c.pcsrc   = 2'b10;
                ctrl_c.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i      (ctrl_c.aluop),
        .funct_i      (bus.funct),
        .alucontrol_o (bus.alucontrol)
    );

    // Strobes are masked by run_q so reset kills them without waiting for a clock
    assign bus.iord      = ctrl_c.iord;
    assign bus.irwrite   = ctrl_c.irwrite   & run_q;
    assign bus.memwrite  = ctrl_c.memwrite  & run_q;
    assign bus.pcwrite   = ctrl_c.pcwrite   & run_q;
    assign bus.branch    = ctrl_c.branch    & run_q;
    assign bus.branch_ne = ctrl_c.branch_ne & run_q;
    assign bus.regwrite  = ctrl_c.regwrite  & run_q;
    assign bus.illegal   = illegal_c        & run_q;
    assign bus.regdst    = ctrl_c.regdst;
    assign bus.memtoreg  = ctrl_c.memtoreg;
    assign bus.alusrca   = ctrl_c.alusrca;
    assign bus.alusrcb   = ctrl_c.alusrcb;
    assign bus.pcsrc     = ctrl_c.pcsrc;
    assign bus.aluop     = ctrl_c.aluop;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: per-instruction expected control sequences from a state-list model.
module tb_mc_maindec;
    import mc_maindec_pkg::*;

    localparam int unsigned V_W = 24;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    mc_maindec_if bus_a ();
    mc_maindec_if bus_b ();

    mc_maindec #(.ENABLE_BNE(1'b1)) dut    (.clk(clk), .resetn(resetn), .bus(bus_a));
    mc_maindec #(.ENABLE_BNE(1'b0)) dut_nb (.clk(clk), .resetn(resetn), .bus(bus_b));

    logic [V_W-1:0] obs_a, obs_b;
    assign obs_a = {bus_a.state, bus_a.iord, bus_a.irwrite, bus_a.memwrite, bus_a.pcwrite,
                    bus_a.branch, bus_a.branch_ne, bus_a.regwrite, bus_a.regdst, bus_a.memtoreg,
                    bus_a.alusrca, bus_a.alusrcb, bus_a.pcsrc, bus_a.aluop, bus_a.alucontrol,
                    bus_a.illegal};
    assign obs_b = {bus_b.state, bus_b.iord, bus_b.irwrite, bus_b.memwrite, bus_b.pcwrite,
                    bus_b.branch, bus_b.branch_ne, bus_b.regwrite, bus_b.regdst, bus_b.memtoreg,
                    bus_b.alusrca, bus_b.alusrcb, bus_b.pcsrc, bus_b.aluop, bus_b.alucontrol,
                    bus_b.illegal};

    // FETCH-valued outputs with every strobe held low
    localparam logic [V_W-1:0] RST_VEC = {4'd0, 10'b0, 2'b01, 2'b00, 2'b00, 3'b010, 1'b0};

    function automatic logic [2:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [V_W-1:0] exp_vec(input state_e s, input logic [5:0] opc,
                                               input logic [5:0] fn, input bit ill);
        logic iord, irw, mw, pcw, br, brne, rw, rd, m2r, asa, illg;
        logic [1:0] asb, pcs, aop;
        {iord, irw, mw, pcw, br, brne, rw, rd, m2r, asa, illg} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (s)
            S_FETCH:   begin irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
            S_DECODE:  begin asb = 2'b11; illg = ill; end
            S_MEMADR:  begin asa = 1'b1; asb = 2'b10; end
            S_MEMRD:   iord = 1'b1;
            S_MEMWR:   begin iord = 1'b1; mw = 1'b1; end
            S_MEMWB:   begin m2r = 1'b1; rw = 1'b1; end
            S_EXECUTE: begin asa = 1'b1; aop = 2'b10; end
            S_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
            S_ADDIEX:  begin asa = 1'b1; asb = 2'b10; end
            S_ADDIWB:  rw = 1'b1;
            S_BRANCH:  begin
                asa = 1'b1; aop = 2'b01; pcs = 2'b01;
                br = (opc == 6'b000100); brne = (opc == 6'b000101);
            end
            S_JUMP:    begin pcs = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {4'(s), iord, irw, mw, pcw, br, brne, rw, rd, m2r, asa, asb, pcs, aop,
                ref_alu(aop, fn), illg};
    endfunction

    // Instruction = its list of visited states; an instruction that stops after DECODE is illegal
    task automatic build(input logic [5:0] opc, input logic [5:0] fn, input bit en,
                         output logic [V_W-1:0] q[$]);
        state_e seq[$];
        bit ill;
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (opc)
            6'b100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
            6'b101011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
            6'b000000: begin seq.push_back(S_EXECUTE); seq.push_back(S_ALUWB); end
            6'b001000: begin seq.push_back(S_ADDIEX); seq.push_back(S_ADDIWB); end
            6'b000100: seq.push_back(S_BRANCH);
            6'b000101: if (en) seq.push_back(S_BRANCH);
            6'b000010: seq.push_back(S_JUMP);
            default: ;
        endcase
        ill = (seq.size() == 2);
        q = {};
        foreach (seq[i]) q.push_back(exp_vec(seq[i], opc, fn, ill));
    endtask

    task automatic check(input string tag, input int cyc, input logic [V_W-1:0] o,
                         input logic [V_W-1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d: got %h want %h", tag, cyc, o, e);
        end
    endtask

    // One instruction, checked every cycle at mid-cycle; abort_at>=0 pulses reset in that cycle
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input bit chk_nb,
                             input int abort_at);
        logic [V_W-1:0] qa[$];
        logic [V_W-1:0] qb[$];
        build(opc, fn, 1'b1, qa);
        build(opc, fn, 1'b0, qb);
        while (qb.size() < qa.size()) qb.push_back(exp_vec(S_FETCH, opc, fn, 1'b0));
        for (int i = 0; i < qa.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_a.op = opc; bus_a.funct = fn;
                bus_b.op = opc; bus_b.funct = fn;
            end
            #1;
            check($sformatf("op%b", opc), i, obs_a, qa[i]);
            if (chk_nb) check($sformatf("nb_op%b", opc), i, obs_b, qb[i]);
            check("wr_excl", i, V_W'(bus_a.memwrite & (bus_a.irwrite | ~bus_a.iord)), '0);
            if (i == abort_at) begin
                #1 resetn = 1'b0;
                #1 check("async_rst", i, obs_a, RST_VEC);
                return;
            end
        end
    endtask

    logic [5:0] op_tab [7];
    logic [5:0] fn_tab [5];

    initial begin
        op_tab = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
        fn_tab = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        bus_a.op = '0; bus_a.funct = '0;
        bus_b.op = '0; bus_b.funct = '0;

        #12;
        check("rst_a", 0, obs_a, RST_VEC);
        check("rst_nb", 0, obs_b, RST_VEC);
        @(negedge clk) resetn = 1'b1;

        run_instr(OP_BNE, F_ADD, 1'b1, -1);
        run_instr(OP_LW,  F_ADD, 1'b0, -1);
        run_instr(OP_SW,  F_SUB, 1'b0, -1);
        run_instr(OP_RTYPE, F_SLT, 1'b0, -1);
        run_instr(OP_RTYPE, F_AND, 1'b0, -1);
        run_instr(OP_J,   F_OR,  1'b0, -1);
        run_instr(OP_ADDI, F_ADD, 1'b0, -1);
        run_instr(OP_BEQ, F_SUB, 1'b0, -1);
        run_instr(6'b111111, F_ADD, 1'b0, -1);
        run_instr(OP_RTYPE, 6'b111000, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] opc, fn;
            opc = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_tab[$urandom_range(0, 6)];
            fn  = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
            run_instr(opc, fn, 1'b0, -1);
        end

        // Reset in the middle of a store: strobes drop at once and stay low across an edge
        run_instr(OP_SW, F_ADD, 1'b0, 3);
        @(posedge clk);
        #1 check("rst_hold", 0, obs_a, RST_VEC);
        @(negedge clk) resetn = 1'b1;
        run_instr(OP_LW, F_ADD, 1'b1, -1);
        run_instr(OP_BNE, F_SUB, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
